// File: rtl/hazard_pkg.sv
// hazard_pkg: shared encodings, latency defaults and clog2 for the hazard unit
package hazard_pkg;
  localparam int TUSE_NONE = -1;
  localparam int TNEW_READY = 0;
  localparam int MULT_LAT_DEF = 5;
  localparam int DIV_LAT_DEF = 10;
  localparam int FWD_RF = 0;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/hazard_match.sv
// hazard_match: nearest-producer search for one D-stage source operand
module hazard_match import hazard_pkg::*; #(
  parameter int NSTG = 3,
  parameter int TW = 2,
  parameter int SW = clog2(NSTG + 1)
) (
  input  logic [4:0]         src,
  input  logic [TW-1:0]      tuse,
  input  logic [5*NSTG-1:0]  a3,
  input  logic [NSTG-1:0]    we,
  input  logic [TW*NSTG-1:0] tnew,
  output logic               stall,
  output logic [SW-1:0]      sel
);
  logic [NSTG-1:0] hit;
  for (genvar k = 0; k < NSTG; k++) begin : g_hit
    assign hit[k] = we[k] && (a3[5*k +: 5] == src);
  end
  // Scan oldest to newest so the nearest match is the one left standing.
  always_comb begin
    stall = 1'b0;
    sel = SW'(FWD_RF);
    if (src != 5'd0 && tuse != TW'(TUSE_NONE))
      for (int i = NSTG - 1; i >= 0; i--)
        if (hit[i]) begin
          stall = tuse < tnew[i*TW +: TW];
          sel = (tnew[i*TW +: TW] == TW'(TNEW_READY)) ? SW'(i + 1) : SW'(FWD_RF);
        end
  end
endmodule

// File: rtl/hazard_unit.sv
// hazard_unit: Tuse/Tnew stall, forward and MDU-busy control for the D stage.
// Define HAZARD_PERF_EN to add stall_cnt/fwd_cnt performance counters.
module hazard_unit import hazard_pkg::*; #(
  parameter int NSTG = 3,
  parameter int TW = 2,
  parameter int MULT_LAT = MULT_LAT_DEF,
  parameter int DIV_LAT = DIV_LAT_DEF
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [4:0]                  rs_D,
  input  logic [4:0]                  rt_D,
  input  logic [TW-1:0]               tuse_rs_D,
  input  logic [TW-1:0]               tuse_rt_D,
  input  logic                        md_use_D,
  input  logic [5*NSTG-1:0]           a3_S,
  input  logic [NSTG-1:0]             we_S,
  input  logic [TW*NSTG-1:0]          tnew_S,
  input  logic                        md_start_E,
  input  logic                        md_div_E,
  output logic                        stall,
  output logic                        flush_E,
  output logic                        md_busy,
  output logic [clog2(NSTG+1)-1:0]    fwd_rs,
  output logic [clog2(NSTG+1)-1:0]    fwd_rt
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]                 stall_cnt,
  output logic [31:0]                 fwd_cnt
`endif
);
  localparam int SW = clog2(NSTG + 1);
  localparam int CW = clog2((MULT_LAT > DIV_LAT ? MULT_LAT : DIV_LAT) + 1);
  logic rs_stall, rt_stall;
  logic [CW-1:0] md_cnt;
  hazard_match #(.NSTG(NSTG), .TW(TW), .SW(SW)) u_rs (
    .src(rs_D), .tuse(tuse_rs_D), .a3(a3_S), .we(we_S), .tnew(tnew_S),
    .stall(rs_stall), .sel(fwd_rs)
  );
  hazard_match #(.NSTG(NSTG), .TW(TW), .SW(SW)) u_rt (
    .src(rt_D), .tuse(tuse_rt_D), .a3(a3_S), .we(we_S), .tnew(tnew_S),
    .stall(rt_stall), .sel(fwd_rt)
  );
  // A new issue always reloads; a legal program is held off by the MDU stall.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) md_cnt <= '0;
    else md_cnt <= md_start_E ? (md_div_E ? CW'(DIV_LAT) : CW'(MULT_LAT))
                              : md_cnt - CW'(md_cnt != '0);
  assign md_busy = md_start_E || (md_cnt != '0);
  assign stall = rs_stall || rt_stall || (md_use_D && md_busy);
  assign flush_E = stall;
`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      stall_cnt <= '0;
      fwd_cnt <= '0;
    end else begin
      stall_cnt <= stall_cnt + 32'(stall);
      fwd_cnt <= fwd_cnt + 32'((fwd_rs != '0 || fwd_rt != '0) && !stall);
    end
`endif
endmodule
